// File: rtl/seq_alu_if.sv
// seq_alu_if: valid/ready operand and result channels of the sequential ALU.
interface seq_alu_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    ALUResult;

  modport master (
    output in_valid, SrcA, SrcB, Operation, out_ready,
    input  in_ready, out_valid, ALUResult
  );

  modport slave (
    input  in_valid, SrcA, SrcB, Operation, out_ready,
    output in_ready, out_valid, ALUResult
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked registered ALU with an iterative shift-add multiplier.
// Define SEQ_ALU_DIV_EN to build the iterative restoring divider for DIVU/REMU.
module seq_alu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic      clk,
  input logic      reset,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
`ifdef SEQ_ALU_DIV_EN
    S_DIV  = 2'b11,
`endif
    S_DONE = 2'b10
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [CW-1:0]             cnt;
  logic                      sel_hi;
  logic [DATA_WIDTH-1:0]     mcand;
  logic [2*DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH:0]       mul_sum;
  logic [2*DATA_WIDTH-1:0]   mul_next;
  logic [DATA_WIDTH-1:0]     result_reg;
  logic                      rdy_reg;
  logic                      vld_reg;
  logic                      is_mul;
  logic                      last_iter;
  logic [OPCODE_LENGTH-1:0]  op_in;
`ifdef SEQ_ALU_DIV_EN
  logic                      is_div;
  logic [DATA_WIDTH-1:0]     rem;
  logic [DATA_WIDTH-1:0]     quo;
  logic [DATA_WIDTH-1:0]     dvsr;
  logic [DATA_WIDTH:0]       div_shift;
  logic [DATA_WIDTH-1:0]     rem_next;
  logic [DATA_WIDTH-1:0]     quo_next;
`endif

  assign op_in         = bus.Operation;
  assign bus.in_ready  = rdy_reg;
  assign bus.out_valid = vld_reg;
  assign bus.ALUResult = result_reg;

  // Single-cycle results; DIVU/REMU only land here when the divisor is zero or no divider exists.
  function automatic logic [DATA_WIDTH-1:0] simple_op(input logic [OPCODE_LENGTH-1:0] op,
                                                      input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
    logic [SHW-1:0]        sh;
    logic [DATA_WIDTH-1:0] r;
    sh = b[SHW-1:0];
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a - b;
      4'b0100: r = a ^ b;
      4'b0101: r = a << sh;
      4'b0110: r = a >> sh;
      4'b0111: r = $signed(a) >>> sh;
      4'b1000: r = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      4'b1001: r = {{(DATA_WIDTH-1){1'b0}}, (a != b)};
      4'b1010: r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1011: r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
`ifdef SEQ_ALU_DIV_EN
      4'b1110: r = {DATA_WIDTH{1'b1}};
      4'b1111: r = a;
`endif
      default: r = {DATA_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // One multiplier bit per step: conditional add into the upper half, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
             + (acc[0] ? {1'b0, mcand} : {(DATA_WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[DATA_WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  // Restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    div_shift = {rem, quo[DATA_WIDTH-1]};
    if (div_shift >= {1'b0, dvsr}) begin
      rem_next = DATA_WIDTH'(div_shift - {1'b0, dvsr});
      quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_next = div_shift[DATA_WIDTH-1:0];
      quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Next-state decode.
  always_comb begin
    is_mul     = (op_in[3:1] == 3'b110);
`ifdef SEQ_ALU_DIV_EN
    is_div     = (op_in[3:1] == 3'b111) && (bus.SrcB != {DATA_WIDTH{1'b0}});
`endif
    last_iter  = (cnt == CNT_ONE);
    next_state = state;
    case (state)
      S_IDLE: begin
        if (!bus.in_valid) next_state = S_IDLE;
        else if (is_mul)   next_state = S_MUL;
`ifdef SEQ_ALU_DIV_EN
        else if (is_div)   next_state = S_DIV;
`endif
        else               next_state = S_DONE;
      end
      S_MUL:  next_state = last_iter ? S_DONE : S_MUL;
`ifdef SEQ_ALU_DIV_EN
      S_DIV:  next_state = last_iter ? S_DONE : S_DIV;
`endif
      S_DONE: next_state = bus.out_ready ? S_IDLE : S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_reg    <= 1'b1;
      vld_reg    <= 1'b0;
      result_reg <= {DATA_WIDTH{1'b0}};
      cnt        <= {CW{1'b0}};
      sel_hi     <= 1'b0;
      mcand      <= {DATA_WIDTH{1'b0}};
      acc        <= {(2*DATA_WIDTH){1'b0}};
`ifdef SEQ_ALU_DIV_EN
      rem        <= {DATA_WIDTH{1'b0}};
      quo        <= {DATA_WIDTH{1'b0}};
      dvsr       <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      rdy_reg <= (next_state == S_IDLE);
      vld_reg <= (next_state == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sel_hi <= op_in[0];
            cnt    <= CNT_LOAD;
            mcand  <= bus.SrcA;
            acc    <= {{DATA_WIDTH{1'b0}}, bus.SrcB};
`ifdef SEQ_ALU_DIV_EN
            rem    <= {DATA_WIDTH{1'b0}};
            quo    <= bus.SrcA;
            dvsr   <= bus.SrcB;
`endif
            if (next_state == S_DONE) result_reg <= simple_op(op_in, bus.SrcA, bus.SrcB);
            else                      result_reg <= result_reg;
          end else begin
            result_reg <= result_reg;
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt - CNT_ONE;
          if (last_iter)
            result_reg <= sel_hi ? mul_next[2*DATA_WIDTH-1:DATA_WIDTH] : mul_next[DATA_WIDTH-1:0];
          else
            result_reg <= result_reg;
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - CNT_ONE;
          if (last_iter) result_reg <= sel_hi ? rem_next : quo_next;
          else           result_reg <= result_reg;
        end
`endif
        S_DONE:  result_reg <= result_reg;
        default: result_reg <= result_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random operations, scoreboard queue checked by a decoupled monitor.
`timescale 1ns/1ps
module tb_seq_alu;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] res;
    int            lat;
    int            acc_edge;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   rdy_mode = 1;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  seq_alu_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) bus();

  seq_alu #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model from the operation table, using plain integer arithmetic.
  function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [63:0] p;
    int          sh;
    sh = int'(b % 32);
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $signed(a) >>> sh;
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return (a != b) ? 32'd1 : 32'd0;
      4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: return (a < b) ? 32'd1 : 32'd0;
      4'd12: return p[31:0];
      4'd13: return p[63:32];
`ifdef SEQ_ALU_DIV_EN
      4'd14: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd15: return (b == 32'd0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [DW-1:0] b);
    if (op == 4'd12 || op == 4'd13) return DW + 1;
`ifdef SEQ_ALU_DIV_EN
    if ((op == 4'd14 || op == 4'd15) && b != 32'd0) return DW + 1;
`endif
    return 1;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] exp_res, input int exp_lat);
    int   t;
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      e.res      = exp_res;
      e.lat      = exp_lat;
      e.acc_edge = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
    bus.Operation = 4'($urandom_range(0, 15));
  endtask

  task automatic issue_ref(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    issue(op, a, b, ref_result(op, a, b), ref_lat(op, b));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Consumer ready: held low, held high, or randomised each cycle.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (sb.size() > 0 && cyc >= sb[0].acc_edge)
          check("in_ready_busy", 64'(bus.in_ready), 64'd0);
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
          end else begin
            if (!prev_valid)
              check("latency", 64'(cyc - sb[0].acc_edge + 1), 64'(sb[0].lat));
            check("result", 64'(bus.ALUResult), 64'(sb[0].res));
            if (bus.out_ready) void'(sb.pop_front());
          end
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bus.in_valid  = 1'b0;
    bus.Operation = 4'd0;
    bus.SrcA      = 32'd0;
    bus.SrcB      = 32'd0;
    reset         = 1'b1;
    @(posedge clk); #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_result", 64'(bus.ALUResult), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    rdy_mode = 1;
    issue(4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    issue(4'd10, 32'h8000_0000, 32'd1, 32'd1, 1);
    issue(4'd11, 32'h8000_0000, 32'd1, 32'd0, 1);
    issue(4'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1);
    issue(4'd6, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1);
    issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
`ifdef SEQ_ALU_DIV_EN
    issue(4'd14, 32'd100, 32'd7, 32'd14, 33);
    issue(4'd15, 32'd100, 32'd7, 32'd2, 33);
    issue(4'd14, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    issue(4'd15, 32'd5, 32'd0, 32'd5, 1);
`else
    issue(4'd14, 32'd100, 32'd7, 32'd0, 1);
    issue(4'd15, 32'd100, 32'd7, 32'd0, 1);
`endif
    drain();

    // Backpressure: result held, new requests refused until the consumer takes it.
    rdy_mode = 0;
    issue(4'd3, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
    repeat (10) @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.Operation = 4'd2;
    bus.SrcA      = 32'd1;
    bus.SrcB      = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
    rdy_mode = 1;
    @(posedge clk); #1;
    rdy_mode = 0;
    @(negedge clk);
    check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    check("bp_out_valid_after", 64'(bus.out_valid), 64'd0);
    check("bp_queue_empty", 64'(sb.size()), 64'd0);
    sb.delete();

    // Reset in the middle of a multiply.
    rdy_mode = 1;
    issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midmul_out_valid", 64'(bus.out_valid), 64'd0);
    check("midmul_result", 64'(bus.ALUResult), 64'd0);
    check("midmul_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(4'd2, 32'd2, 32'd3, 32'd5, 1);
    drain();

    // Random operations with a randomly stalling consumer.
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = b;
      issue_ref(op, a, b);
    end
    drain();
    rdy_mode = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Handshaked, registered integer ALU that replaces the purely combinational datapath ALU wherever multi-cycle arithmetic is needed. It is parametrised in data width. It extends the base operation set with XOR, shifts, signed and unsigned set-less-than, an iterative shift-add multiplier and an optional iterative restoring divider. It accepts one operation at a time through a valid/ready input port and presents the result on a valid/ready output port, so the execute stage can stall on it.

## Interface
- DATA_WIDTH, 32: operand and result width; a power of two, at least 8.
- OPCODE_LENGTH, 4: operation code width; fixed at 4 for the encoding below.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  SrcA, SrcB and Operation are valid this cycle.
- in_ready  output  1  the block can accept an operation.
- SrcA  input  DATA_WIDTH  first operand.
- SrcB  input  DATA_WIDTH  second operand; its low $clog2(DATA_WIDTH) bits give the shift amount.
- Operation  input  OPCODE_LENGTH  operation code.
- out_valid  output  1  ALUResult holds a completed result.
- out_ready  input  1  the consumer takes the result this cycle.
- ALUResult  output  DATA_WIDTH  result register.

## Operation
- Encoding:
  - 0000 AND; 0001 OR (bitwise); 0010 ADD; 0011 SUB.
  - 0100 XOR; 0101 SLL; 0110 SRL; 0111 SRA.
  - 1000 EQ; 1001 NE; 1010 SLT (signed); 1011 SLTU.
  - 1100 MUL (low half); 1101 MULHU (high half, unsigned).
  - 1110 DIVU; 1111 REMU.
- ADD and SUB wrap modulo 2^DATA_WIDTH. EQ, NE, SLT and SLTU return 1 or 0, zero-extended.
- Operands and the opcode are captured into internal registers on acceptance. Input changes after acceptance have no effect.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready=1. On in_valid, the operation is accepted.
    - Simple ops (0000-1011), and DIVU/REMU with SrcB==0, compute the result and go to DONE.
    - 1100/1101 go to MUL.
    - 1110/1111 with SrcB!=0 go to DIV.
  - MUL: shift-add, one multiplier bit per cycle into a 2*DATA_WIDTH accumulator. After DATA_WIDTH iterations, load the low half (MUL) or high half (MULHU) into ALUResult and go to DONE.
  - DIV: restoring division, one quotient bit per cycle. After DATA_WIDTH iterations, load the quotient (DIVU) or remainder (REMU) and go to DONE.
  - DONE: out_valid=1 and ALUResult is held stable. On out_ready, go to IDLE.
- Divide by zero: DIVU returns all ones; REMU returns SrcA. Both are single-cycle.
- The iteration counter is $clog2(DATA_WIDTH)+1 bits wide. It loads DATA_WIDTH on entry to MUL or DIV and the state exits when the counter reaches 1.
- in_ready is 0 in MUL, DIV and DONE. in_valid in those states is ignored; the producer must hold its request.

## Timing
- Reset (asynchronous): state=IDLE, in_ready=1, out_valid=0, ALUResult=0, counter and accumulators cleared.
- Acceptance at rising edge N, where in_valid and in_ready are both 1.
- Simple-op latency: out_valid=1 from cycle N+1.
- MUL/DIV latency: out_valid=1 from cycle N+1+DATA_WIDTH.
- out_valid and ALUResult stay stable until the edge where out_ready=1. in_ready returns to 1 on the next cycle.
- Peak throughput: one operation per 2 cycles, with out_ready tied high.
- reset asserted in any state, including mid-MUL or mid-DIV, aborts the operation. Outputs take their reset values immediately. No partial result is ever presented.

## Configuration
- SEQ_ALU_DIV_EN defined:
  - The DIV state and the divider datapath are built.
  - DIVU/REMU behave as described under Operation.
- SEQ_ALU_DIV_EN undefined:
  - No DIV state and no divider registers exist.
  - 1110 and 1111 are treated as simple ops: ALUResult=0, out_valid on cycle N+1.

## Test plan
- ADD, DATA_WIDTH=32: SrcA=0x7FFFFFFF, SrcB=1, out_ready=1 -> out_valid on the cycle after acceptance, ALUResult=0x80000000. Then SLT with SrcA=0x80000000, SrcB=1 -> 1. Then SLTU with the same operands -> 0.
- SRA: SrcA=0x80000000, SrcB=0x00000024 (shift amount 4) -> 0xF8000000. SRL with the same operands -> 0x08000000.
- MUL and MULHU: SrcA=SrcB=0xFFFFFFFF -> MUL gives 0x00000001, MULHU gives 0xFFFFFFFE. out_valid is first high exactly 33 cycles after acceptance. in_ready=0 throughout.
- With SEQ_ALU_DIV_EN defined:
  - DIVU 100/7 -> 14 and REMU 100/7 -> 2, each after 33 cycles.
  - DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each after 1 cycle.
- With SEQ_ALU_DIV_EN undefined: DIVU 100/7 -> 0 after 1 cycle.
- Backpressure: out_ready=0 for 10 cycles after a SUB 3-5 -> ALUResult=0xFFFFFFFE held with out_valid=1. A new in_valid during that time is not accepted. After out_ready pulses high for one cycle, in_ready=1 on the following cycle.
- Reset mid-MUL: assert reset 10 cycles into a MUL -> out_valid=0 and ALUResult=0 immediately, in_ready=1. A following ADD 2+3 returns 5 with 1-cycle latency.
